mem_burst_master: RTL and testbench

MEM_BURST_MASTER -- requirements
Module: mem_burst_master

---
 rtl/mem_burst_master.sv | 187 ++++++++++++++++++
 tb/tb_mem_burst_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_master.sv
// Burst master that turns one request (start address, beat count, direction)
// into consecutive word accesses on a simple single-port memory interface.
// Writes are paced by the incoming write-beat stream. Reads issue one address
// per cycle. When SHOWAHEAD=0 the memory returns data one cycle after the
// address, so a one-stage valid/last pipeline follows it and a DRAIN state
// presents the final beat.
module mem_burst_master #(
  parameter int MEM_WIDTH_BYTES = 8,
  parameter int MEM_DEPTH       = 1024,
  parameter int SHOWAHEAD       = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid_in,
  output logic                             req_ready_out,
  input  logic                             req_write_in,
  input  logic [$clog2(MEM_DEPTH)-1:0]     req_addr_in,
  input  logic [7:0]                       req_len_in,
  input  logic                             wdata_valid_in,
  output logic                             wdata_ready_out,
  input  logic [MEM_WIDTH_BYTES*8-1:0]     wdata_in,
  input  logic [MEM_WIDTH_BYTES-1:0]       wmask_in,
  output logic                             rdata_valid_out,
  output logic [MEM_WIDTH_BYTES*8-1:0]     rdata_out,
  output logic                             rdata_last_out,
  output logic                             mem_write_out,
  output logic [$clog2(MEM_DEPTH)-1:0]     mem_write_addr_out,
  output logic [MEM_WIDTH_BYTES*8-1:0]     mem_write_data_out,
  output logic [MEM_WIDTH_BYTES-1:0]       mem_write_mask_out,
  output logic                             mem_read_out,
  output logic [$clog2(MEM_DEPTH)-1:0]     mem_read_addr_out,
  input  logic [MEM_WIDTH_BYTES*8-1:0]     mem_read_data_in,
  output logic                             busy_out,
  input  logic                             debugen_in
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cur_addr_q, cur_addr_d;
  logic [7:0]      beats_left_q, beats_left_d;
  logic            is_write_q, is_write_d;
  logic            req_fire;
  logic            last_beat;
  logic [AW-1:0]   addr_inc;

  // The trace enable has no functional effect; simulation wrappers observe
  // the port directly to print per-cycle traces.
  logic debugen_unused;
  assign debugen_unused = debugen_in;

  assign req_fire  = req_valid_in && req_ready_out;
  assign last_beat = (beats_left_q == 8'd0);
  // Explicit wrap so depths that are not a power of two still wrap at MEM_DEPTH-1.
  assign addr_inc  = (cur_addr_q == AW'(MEM_DEPTH - 1)) ? '0 : cur_addr_q + AW'(1);

  // State register; reset returns to IDLE and aborts any burst.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: write bursts end on the last accepted beat, read
  // bursts end after the last issue (plus one DRAIN cycle without showahead).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req_fire) state_d = req_write_in ? ST_WRITE : ST_READ;
      ST_WRITE: if (wdata_valid_in && last_beat) state_d = ST_IDLE;
      ST_READ:  if (last_beat) state_d = (SHOWAHEAD != 0) ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode; every strobe is held low while reset is asserted. The
  // direction bit also gates the strobes so they can never both be high.
  always_comb begin
    req_ready_out   = 1'b0;
    wdata_ready_out = 1'b0;
    mem_write_out   = 1'b0;
    mem_read_out    = 1'b0;
    busy_out        = 1'b0;
    if (reset) begin
      busy_out = (state_q != ST_IDLE);
      unique case (state_q)
        ST_IDLE:  req_ready_out = 1'b1;
        ST_WRITE: begin
          wdata_ready_out = 1'b1;
          mem_write_out   = wdata_valid_in && is_write_q;
        end
        ST_READ:  mem_read_out = !is_write_q;
        default:  ;
      endcase
    end
  end

  // Burst bookkeeping: latch the request, then step address and count per beat.
  always_comb begin
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    is_write_d   = is_write_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          cur_addr_d   = req_addr_in;
          beats_left_d = req_len_in;
          is_write_d   = req_write_in;
        end
      end
      ST_WRITE: begin
        if (wdata_valid_in) begin
          cur_addr_d   = addr_inc;
          beats_left_d = beats_left_q - 8'd1;
        end
      end
      ST_READ: begin
        cur_addr_d   = addr_inc;
        beats_left_d = beats_left_q - 8'd1;
      end
      default: ;
    endcase
  end

  // Burst bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_addr_q   <= '0;
      beats_left_q <= 8'd0;
      is_write_q   <= 1'b0;
    end else begin
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      is_write_q   <= is_write_d;
    end
  end

  assign mem_write_addr_out = cur_addr_q;
  assign mem_write_data_out = wdata_in;
  assign mem_write_mask_out = wmask_in;
  assign mem_read_addr_out  = cur_addr_q;
  assign rdata_out          = mem_read_data_in;

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      // Data arrives with the address, so the read beat is the issue itself.
      always_comb begin
        rdata_valid_out = mem_read_out;
        rdata_last_out  = mem_read_out && last_beat;
      end
    end else begin : g_registered
      logic rd_valid_q, rd_valid_d;
      logic rd_last_q, rd_last_d;

      // Valid/last follow each issue by one cycle to line up with the data.
      always_comb begin
        rd_valid_d = mem_read_out;
        rd_last_d  = mem_read_out && last_beat;
      end

      // Read pipeline register; reset discards any beat in flight.
      always_ff @(posedge clk) begin
        if (!reset) begin
          rd_valid_q <= 1'b0;
          rd_last_q  <= 1'b0;
        end else begin
          rd_valid_q <= rd_valid_d;
          rd_last_q  <= rd_last_d;
        end
      end

      // Pipeline outputs, forced low while reset is held.
      always_comb begin
        rdata_valid_out = rd_valid_q && reset;
        rdata_last_out  = rd_last_q && reset;
      end
    end
  endgenerate

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: two instances (registered read and showahead)
// share all stimulus. Each one drives its own behavioural RAM, and every beat
// is compared with a reference memory image and per-burst timing rules.
module tb_mem_burst_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [7:0]  req_len = '0;
  logic        wdata_valid = 1'b0;
  logic [63:0] wdata = '0;
  logic [7:0]  wmask = '0;
  logic        debugen = 1'b0;

  logic        req_ready0, wdata_ready0, rv0, rlast0, mw0, mr0, busy0;
  logic        req_ready1, wdata_ready1, rv1, rlast1, mw1, mr1, busy1;
  logic [63:0] rdata0, rdata1, mwd0, mwd1, mrd0, mrd1;
  logic [7:0]  mwm0, mwm1;
  logic [3:0]  mwa0, mwa1, mra0, mra1;

  logic [63:0] ram0 [16];
  logic [63:0] ram1 [16];
  logic [63:0] rdq0;
  logic [63:0] ref_mem [16];

  int n_checks = 0;
  int n_errors = 0;
  bit stall_en = 1'b0;
  bit vpat[$];

  always #5 clk = ~clk;

  mem_burst_master #(.MEM_WIDTH_BYTES(8), .MEM_DEPTH(16), .SHOWAHEAD(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid), .req_ready_out(req_ready0), .req_write_in(req_write),
    .req_addr_in(req_addr), .req_len_in(req_len),
    .wdata_valid_in(wdata_valid), .wdata_ready_out(wdata_ready0), .wdata_in(wdata), .wmask_in(wmask),
    .rdata_valid_out(rv0), .rdata_out(rdata0), .rdata_last_out(rlast0),
    .mem_write_out(mw0), .mem_write_addr_out(mwa0), .mem_write_data_out(mwd0), .mem_write_mask_out(mwm0),
    .mem_read_out(mr0), .mem_read_addr_out(mra0), .mem_read_data_in(mrd0),
    .busy_out(busy0), .debugen_in(debugen)
  );

  mem_burst_master #(.MEM_WIDTH_BYTES(8), .MEM_DEPTH(16), .SHOWAHEAD(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid), .req_ready_out(req_ready1), .req_write_in(req_write),
    .req_addr_in(req_addr), .req_len_in(req_len),
    .wdata_valid_in(wdata_valid), .wdata_ready_out(wdata_ready1), .wdata_in(wdata), .wmask_in(wmask),
    .rdata_valid_out(rv1), .rdata_out(rdata1), .rdata_last_out(rlast1),
    .mem_write_out(mw1), .mem_write_addr_out(mwa1), .mem_write_data_out(mwd1), .mem_write_mask_out(mwm1),
    .mem_read_out(mr1), .mem_read_addr_out(mra1), .mem_read_data_in(mrd1),
    .busy_out(busy1), .debugen_in(debugen)
  );

  // Registered-read RAM for the SHOWAHEAD=0 instance.
  always @(posedge clk) begin
    if (mw0) for (int b = 0; b < 8; b++) if (mwm0[b]) ram0[mwa0][b*8 +: 8] <= mwd0[b*8 +: 8];
    if (mr0) rdq0 <= ram0[mra0];
  end
  assign mrd0 = rdq0;

  // Combinational-read RAM for the SHOWAHEAD=1 instance.
  always @(posedge clk) begin
    if (mw1) for (int b = 0; b < 8; b++) if (mwm1[b]) ram1[mwa1][b*8 +: 8] <= mwd1[b*8 +: 8];
  end
  assign mrd1 = ram1[mra1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] wrap16(input logic [3:0] base, input int off);
    return 4'((int'(base) + off) % 16);
  endfunction

  task automatic do_write(input logic [3:0] addr, input int len,
                          input logic [63:0] dq[$], input logic [7:0] mq[$]);
    int i = 0;
    int cyc = 0;
    logic v;
    logic [3:0] ea;
    $display("txn write addr=%0d len=%0d", addr, len);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = len[7:0];
    #1;
    check("wr req_ready0", req_ready0, 1'b1);
    check("wr req_ready1", req_ready1, 1'b1);
    while (i <= len) begin
      @(negedge clk);
      req_valid = 1'b0;
      cyc++;
      if (vpat.size() > 0) v = vpat.pop_front();
      else v = (stall_en && cyc < 1000) ? ($urandom_range(0, 3) != 0) : 1'b1;
      wdata_valid = v; wdata = dq[i]; wmask = mq[i];
      #1;
      ea = wrap16(addr, i);
      check($sformatf("wr b%0d busy0", i), busy0, 1'b1);
      check($sformatf("wr b%0d busy1", i), busy1, 1'b1);
      check($sformatf("wr b%0d wdata_ready0", i), wdata_ready0, 1'b1);
      check($sformatf("wr b%0d wdata_ready1", i), wdata_ready1, 1'b1);
      check($sformatf("wr b%0d req_ready0", i), req_ready0, 1'b0);
      check($sformatf("wr b%0d mem_write0", i), mw0, v);
      check($sformatf("wr b%0d mem_write1", i), mw1, v);
      check($sformatf("wr b%0d mem_read0", i), mr0, 1'b0);
      check($sformatf("wr b%0d mem_read1", i), mr1, 1'b0);
      if (v) begin
        check($sformatf("wr b%0d waddr0", i), mwa0, ea);
        check($sformatf("wr b%0d waddr1", i), mwa1, ea);
        check($sformatf("wr b%0d wdata0", i), mwd0, dq[i]);
        check($sformatf("wr b%0d wmask0", i), mwm0, mq[i]);
        for (int b = 0; b < 8; b++) if (mq[i][b]) ref_mem[ea][b*8 +: 8] = dq[i][b*8 +: 8];
        i++;
      end
    end
    @(negedge clk);
    wdata_valid = 1'b0;
    #1;
    check("wr end busy0", busy0, 1'b0);
    check("wr end busy1", busy1, 1'b0);
    check("wr end req_ready0", req_ready0, 1'b1);
    check("wr end mem_write0", mw0, 1'b0);
  endtask

  task automatic do_read(input logic [3:0] addr, input int len);
    logic [3:0] ea;
    $display("txn read addr=%0d len=%0d", addr, len);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len[7:0];
    #1;
    check("rd req_ready0", req_ready0, 1'b1);
    for (int k = 0; k <= len + 2; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      ea = wrap16(addr, k);
      // showahead instance: data with the issue, idle right after the last beat
      check($sformatf("rd k%0d mem_read1", k), mr1, k <= len);
      check($sformatf("rd k%0d rvalid1", k), rv1, k <= len);
      check($sformatf("rd k%0d busy1", k), busy1, k <= len);
      if (k <= len) begin
        check($sformatf("rd k%0d raddr1", k), mra1, ea);
        check($sformatf("rd k%0d rdata1", k), rdata1, ref_mem[ea]);
        check($sformatf("rd k%0d rlast1", k), rlast1, k == len);
      end
      // registered instance: data one cycle after issue, one drain cycle
      check($sformatf("rd k%0d mem_read0", k), mr0, k <= len);
      if (k <= len) check($sformatf("rd k%0d raddr0", k), mra0, ea);
      check($sformatf("rd k%0d rvalid0", k), rv0, (k >= 1) && (k <= len + 1));
      if (k >= 1 && k <= len + 1) begin
        check($sformatf("rd k%0d rdata0", k), rdata0, ref_mem[wrap16(addr, k - 1)]);
        check($sformatf("rd k%0d rlast0", k), rlast0, k == len + 1);
      end else begin
        check($sformatf("rd k%0d rlast0", k), rlast0, 1'b0);
      end
      check($sformatf("rd k%0d busy0", k), busy0, k <= len + 1);
      check($sformatf("rd k%0d mem_write0", k), mw0, 1'b0);
      check($sformatf("rd k%0d wdata_ready0", k), wdata_ready0, 1'b0);
    end
  endtask

  task automatic check_quiet(input string tag, input logic exp_ready);
    check({tag, " busy0"}, busy0, 1'b0);
    check({tag, " busy1"}, busy1, 1'b0);
    check({tag, " mem_read0"}, mr0, 1'b0);
    check({tag, " mem_read1"}, mr1, 1'b0);
    check({tag, " mem_write0"}, mw0, 1'b0);
    check({tag, " rvalid0"}, rv0, 1'b0);
    check({tag, " rvalid1"}, rv1, 1'b0);
    check({tag, " rlast0"}, rlast0, 1'b0);
    check({tag, " wdata_ready0"}, wdata_ready0, 1'b0);
    check({tag, " req_ready0"}, req_ready0, exp_ready);
    check({tag, " req_ready1"}, req_ready1, exp_ready);
  endtask

  task automatic reset_mid_read(input logic [3:0] addr);
    $display("txn read addr=%0d len=7 with reset at beat 2", addr);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = 8'd7;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check($sformatf("rst k%0d mem_read0", k), mr0, 1'b1);
      check($sformatf("rst k%0d mem_read1", k), mr1, 1'b1);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_quiet("rst during", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_quiet("rst after", 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check_quiet($sformatf("rst idle%0d", k), 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [63:0] dq[$];
    logic [7:0]  mq[$];
    for (int a = 0; a < 16; a++) ref_mem[a] = '0;

    // Reset held for a few cycles, then the first cycle after release.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_quiet($sformatf("por%0d", k), 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_quiet("por release", 1'b1);

    // Define every word so later reads have known contents.
    dq = {}; mq = {};
    for (int i = 0; i < 16; i++) begin dq.push_back({$urandom, $urandom}); mq.push_back(8'hFF); end
    do_write(4'd0, 15, dq, mq);

    // Directed write then read at 4..7.
    dq = {64'h11, 64'h22, 64'h33, 64'h44}; mq = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_write(4'd4, 3, dq, mq);
    do_read(4'd4, 3);

    // Wrap-around across the top of a 16-word memory.
    dq = {}; mq = {};
    for (int i = 0; i < 4; i++) begin dq.push_back({$urandom, $urandom}); mq.push_back(8'hFF); end
    do_write(4'd14, 3, dq, mq);
    do_read(4'd14, 3);

    // Write stall pattern 1,0,0,1.
    vpat = {1'b1, 1'b0, 1'b0, 1'b1};
    dq = {64'hA5A5, 64'h5A5A}; mq = {8'hFF, 8'hFF};
    do_write(4'd9, 1, dq, mq);
    do_read(4'd9, 1);

    // Byte mask: only byte 0 of the all-ones word lands over zero.
    dq = {64'h0}; mq = {8'hFF};
    do_write(4'd2, 0, dq, mq);
    dq = {64'hFFFF_FFFF_FFFF_FFFF}; mq = {8'h01};
    do_write(4'd2, 0, dq, mq);
    do_read(4'd2, 0);

    // Randomized bursts with random write stalls, including 256-beat bursts.
    stall_en = 1'b1;
    for (int t = 0; t < 24; t++) begin
      int len;
      logic [3:0] addr;
      addr = 4'($urandom_range(0, 15));
      len = (t == 10 || t == 11) ? 255 : int'($urandom_range(0, 20));
      if ((t % 2) == 0) begin
        dq = {}; mq = {};
        for (int i = 0; i <= len; i++) begin
          dq.push_back({$urandom, $urandom});
          mq.push_back(8'($urandom));
        end
        do_write(addr, len, dq, mq);
      end else begin
        do_read(addr, len);
      end
    end
    stall_en = 1'b0;

    // Reset in the middle of a read, then confirm recovery.
    reset_mid_read(4'd3);
    do_read(4'd5, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
